// File: rtl/ysyx_24100005_imem_resp.sv
// ---------------------------------------------------------------------------
// ysyx_24100005_imem_resp
//
// Instruction-memory responder for the fetch side of the core. It accepts one
// word-aligned fetch address per req handshake, waits a fixed LAT cycles, and
// then presents the 32-bit instruction on a valid/ready response channel. The
// storage is a word-addressed array whose word 0 sits at BASE_ADDR (the core
// reset PC). A side write port preloads the program image.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset (array contents are kept)
//   req_valid  fetch request present
//   req_ready  responder idle and able to accept a request
//   req_addr   fetch byte address
//   resp_valid response word valid (held until resp_ready)
//   resp_ready core accepts the response
//   resp_inst  fetched instruction, or ERR_INST on an access error
//   resp_err   request was misaligned or outside the array
//   load_en    preload write strobe (honoured in every state, even in reset)
//   load_addr  preload byte address (misaligned/out-of-range writes dropped)
//   load_data  preload word
//
// LAT must lie in 1..15; the latency counter is four bits wide.
// ---------------------------------------------------------------------------
module ysyx_24100005_imem_resp #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned LAT       = 2,
  parameter logic [31:0] ERR_INST  = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Range bounds are kept in 33 bits so BASE_ADDR + 4*DEPTH can reach or
  // exceed 2^32 without wrapping back into the low address space.
  localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_EXT = BASE_EXT + (33'(DEPTH) << 2);
  localparam logic [3:0]  LAT_M1    = 4'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Address decode helpers
  // -------------------------------------------------------------------------
  function automatic logic addr_ok(input logic [31:0] a);
    logic [32:0] a_ext;
    a_ext = {1'b0, a};
    return (a[1:0] == 2'b00) && (a_ext >= BASE_EXT) && (a_ext < LIMIT_EXT);
  endfunction

  // Word index of an in-range address; meaningless when addr_ok() is false.
  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  // -------------------------------------------------------------------------
  // Storage and preload port. Not reset: a program image loaded while rst is
  // high must survive the reset.
  // -------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (load_en && addr_ok(load_addr)) begin
      mem[addr_idx(load_addr)] <= load_data;
    end
  end

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] resp_inst_reg;
  logic        resp_err_reg;
  logic        capture;

  // Address used by the capture edge. With LAT=1 the capture edge is the
  // accepting edge itself, so the address has not reached addr_reg yet and
  // must come straight from the request port.
  logic [31:0] cap_addr;
  logic        cap_ok;
  logic [31:0] rd_word;

  always_comb begin
    cap_addr = (state_reg == S_IDLE) ? req_addr : addr_reg;
  end

  // The read happens before any same-edge preload write lands, so a write to
  // the word being captured on that edge is not seen: the old word is taken.
  always_comb begin
    cap_ok  = addr_ok(cap_addr);
    rd_word = mem[addr_idx(cap_addr)];
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    capture    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          addr_next = req_addr;
          cnt_next  = LAT_M1;
          if (LAT == 1) begin
            state_next = S_RESP;
            capture    = 1'b1;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = S_RESP;
          capture    = 1'b1;
        end
      end
      S_RESP: begin
        // Response fields stay frozen here; only the handshake moves us on.
        if (resp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 4'd0;
      addr_reg      <= 32'd0;
      resp_inst_reg <= 32'd0;
      resp_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      if (capture) begin
        resp_err_reg  <= ~cap_ok;
        resp_inst_reg <= cap_ok ? rd_word : ERR_INST;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs are pure functions of registered state.
  // -------------------------------------------------------------------------
  always_comb begin
    req_ready  = (state_reg == S_IDLE);
    resp_valid = (state_reg == S_RESP);
    resp_inst  = resp_inst_reg;
    resp_err   = resp_err_reg;
  end

endmodule

// File: tb/tb_ysyx_24100005_imem_resp.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_24100005_imem_resp. Two instances share clock, reset and
// the preload port: dut uses LAT=2, dut1 uses LAT=1. Inputs are driven 1 ns
// after the rising edge and outputs are sampled at the same point, so
// "cycle n" is the interval following the n-th edge after a request starts.
// ---------------------------------------------------------------------------
module tb_ysyx_24100005_imem_resp;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] ERRW = 32'h0010_0073;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, resp_inst;

  logic        req_valid1, req_ready1, resp_valid1, resp_ready1, resp_err1;
  logic [31:0] req_addr1, resp_inst1;

  int n_checks;
  int n_fail;

  ysyx_24100005_imem_resp #(.LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_inst(resp_inst), .resp_err(resp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  ysyx_24100005_imem_resp #(.LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_inst(resp_inst1), .resp_err(resp_err1),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  // Issues one request on the LAT=2 instance with resp_ready high and reports
  // what came back; cyc is the cycle resp_valid was first seen (-1 = none).
  task automatic fetch(input logic [31:0] a, output logic [31:0] inst,
                       output logic err, output int cyc);
    cyc  = -1;
    inst = 32'd0;
    err  = 1'b0;
    req_valid  = 1'b1;
    req_addr   = a;
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (resp_valid) begin
        cyc  = i;
        inst = resp_inst;
        err  = resp_err;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid);
    end
    n_checks++;
    if (resp_inst !== 32'd0) begin
      n_fail++; $display("FAIL reset_resp_inst: got %h want 0", resp_inst);
    end
    n_checks++;
    if (resp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp_err: got %b want 0", resp_err);
    end
    n_checks++;
    if (req_ready1 !== 1'b1 || resp_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_lat1: got rdy=%b vld=%b want 1/0", req_ready1, resp_valid1);
    end
    $display("reset: done");
  endtask

  task automatic test_basic();
    load_word(BASE, 32'h0010_0093);
    // cycle 0
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_c0_ready: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_addr = BASE; resp_ready = 1'b1;
    tick();
    // cycle 1
    req_valid = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_c1: got vld=%b rdy=%b want 0/0", resp_valid, req_ready);
    end
    tick();
    // cycle 2
    n_checks++;
    if (resp_valid !== 1'b1 || resp_inst !== 32'h0010_0093 || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL basic_c2: got vld=%b inst=%h err=%b want 1/00100093/0",
                         resp_valid, resp_inst, resp_err);
    end
    tick();
    // cycle 3
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_c3: got rdy=%b vld=%b want 1/0", req_ready, resp_valid);
    end
    $display("basic: fetch %h -> %h", BASE, resp_inst);
  endtask

  task automatic test_errors();
    logic [31:0] bad [4];
    logic [31:0] inst;
    logic        err;
    int          cyc;
    bad[0] = 32'h8000_0002;
    bad[1] = 32'h7FFF_FFFC;
    bad[2] = 32'h8000_4000;
    bad[3] = 32'hFFFF_FFFC;
    for (int i = 0; i < 4; i++) begin
      fetch(bad[i], inst, err, cyc);
      n_checks++;
      if (cyc !== 2 || err !== 1'b1 || inst !== ERRW) begin
        n_fail++; $display("FAIL err_addr_%0d: addr=%h got cyc=%0d err=%b inst=%h want 2/1/%h",
                           i, bad[i], cyc, err, inst, ERRW);
      end
      $display("errors: fetch %h -> err=%b inst=%h", bad[i], err, inst);
    end
    // last word of the array is still legal
    load_word(32'h8000_3FFC, 32'h1234_5678);
    fetch(32'h8000_3FFC, inst, err, cyc);
    n_checks++;
    if (cyc !== 2 || err !== 1'b0 || inst !== 32'h1234_5678) begin
      n_fail++; $display("FAIL err_top_word: got cyc=%0d err=%b inst=%h want 2/0/12345678",
                         cyc, err, inst);
    end
    // dropped preload: misaligned write must not touch the word below it
    load_word(32'h8000_3FFE, 32'hFFFF_FFFF);
    fetch(32'h8000_3FFC, inst, err, cyc);
    n_checks++;
    if (inst !== 32'h1234_5678) begin
      n_fail++; $display("FAIL err_drop_misaligned_load: got %h want 12345678", inst);
    end
  endtask

  task automatic test_backpressure();
    req_valid = 1'b1; req_addr = BASE; resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (resp_valid !== 1'b1 || resp_inst !== 32'h0010_0093 || req_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold_%0d: got vld=%b inst=%h rdy=%b want 1/00100093/0",
                           i, resp_valid, resp_inst, req_ready);
      end
      // a competing request and a rewrite of the same word during RESP
      req_valid = 1'b1; req_addr = BASE + 32'd4;
      load_en = (i == 1); load_addr = BASE; load_data = 32'hDEAD_BEEF;
      tick();
      load_en = 1'b0;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_inst !== 32'h0010_0093) begin
      n_fail++; $display("FAIL bp_release: got vld=%b inst=%h want 1/00100093", resp_valid, resp_inst);
    end
    tick();
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_idle: got rdy=%b vld=%b want 1/0", req_ready, resp_valid);
    end
    load_word(BASE, 32'h0010_0093);
    $display("backpressure: held 5 cycles, inst=%h", resp_inst);
  endtask

  task automatic test_rw_collision();
    logic [31:0] inst;
    logic        err;
    int          cyc;
    // write lands before the capture edge -> new word
    load_word(BASE + 32'd4, 32'hAAAA_AAAA);
    req_valid = 1'b1; req_addr = BASE + 32'd4; resp_ready = 1'b1;
    load_en = 1'b1; load_addr = BASE + 32'd4; load_data = 32'hBBBB_BBBB;
    tick();
    req_valid = 1'b0; load_en = 1'b0;
    tick();
    n_checks++;
    if (resp_valid !== 1'b1 || resp_inst !== 32'hBBBB_BBBB) begin
      n_fail++; $display("FAIL rw_early_write: got vld=%b inst=%h want 1/bbbbbbbb", resp_valid, resp_inst);
    end
    tick();
    $display("rw: early write -> %h", resp_inst);
    // write on the capture edge -> old word
    load_word(BASE + 32'd4, 32'hAAAA_AAAA);
    req_valid = 1'b1; req_addr = BASE + 32'd4;
    tick();
    req_valid = 1'b0;
    load_en = 1'b1; load_addr = BASE + 32'd4; load_data = 32'hBBBB_BBBB;
    tick();
    load_en = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_inst !== 32'hAAAA_AAAA) begin
      n_fail++; $display("FAIL rw_capture_edge: got vld=%b inst=%h want 1/aaaaaaaa", resp_valid, resp_inst);
    end
    tick();
    $display("rw: capture-edge write -> %h", resp_inst);
    fetch(BASE + 32'd4, inst, err, cyc);
    n_checks++;
    if (inst !== 32'hBBBB_BBBB || err !== 1'b0) begin
      n_fail++; $display("FAIL rw_after: got inst=%h err=%b want bbbbbbbb/0", inst, err);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] inst;
    logic        err;
    int          cyc;
    // reset while in WAIT, preloading a word at the same time
    req_valid = 1'b1; req_addr = BASE; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    load_en = 1'b1; load_addr = BASE + 32'd8; load_data = 32'hCAFE_F00D;
    tick();
    rst = 1'b0; load_en = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_wait: got vld=%b rdy=%b want 0/1", resp_valid, req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_wait_no_resp_%0d: got vld=%b want 0", i, resp_valid);
      end
      tick();
    end
    $display("reset_mid: reset in WAIT");
    // reset while in RESP
    req_valid = 1'b1; req_addr = BASE; resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; resp_ready = 1'b1;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_inst !== 32'd0) begin
      n_fail++; $display("FAIL rst_resp: got vld=%b rdy=%b inst=%h want 0/1/0",
                         resp_valid, req_ready, resp_inst);
    end
    $display("reset_mid: reset in RESP");
    fetch(BASE + 32'd8, inst, err, cyc);
    n_checks++;
    if (cyc !== 2 || inst !== 32'hCAFE_F00D || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_preload_kept: got cyc=%0d inst=%h err=%b want 2/cafef00d/0",
                         cyc, inst, err);
    end
  endtask

  task automatic test_back_to_back_lat1();
    load_word(BASE + 32'd4, 32'h0020_8113);
    // cycle 0: accept first request
    req_valid1 = 1'b1; req_addr1 = BASE; resp_ready1 = 1'b1;
    n_checks++;
    if (req_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL lat1_c0_ready: got %b want 1", req_ready1);
    end
    tick();
    // cycle 1: first response; second request presented but not yet accepted
    req_addr1 = BASE + 32'd4;
    n_checks++;
    if (resp_valid1 !== 1'b1 || resp_inst1 !== 32'h0010_0093 || req_ready1 !== 1'b0) begin
      n_fail++; $display("FAIL lat1_c1: got vld=%b inst=%h rdy=%b want 1/00100093/0",
                         resp_valid1, resp_inst1, req_ready1);
    end
    tick();
    // cycle 2: second accept
    n_checks++;
    if (req_ready1 !== 1'b1 || resp_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL lat1_c2: got rdy=%b vld=%b want 1/0", req_ready1, resp_valid1);
    end
    tick();
    req_valid1 = 1'b0;
    // cycle 3: second response
    n_checks++;
    if (resp_valid1 !== 1'b1 || resp_inst1 !== 32'h0020_8113 || resp_err1 !== 1'b0) begin
      n_fail++; $display("FAIL lat1_c3: got vld=%b inst=%h err=%b want 1/00208113/0",
                         resp_valid1, resp_inst1, resp_err1);
    end
    tick();
    n_checks++;
    if (req_ready1 !== 1'b1 || resp_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL lat1_c4: got rdy=%b vld=%b want 1/0", req_ready1, resp_valid1);
    end
    $display("lat1: back-to-back responses in cycles 1 and 3");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    load_en = 1'b0; load_addr = 32'd0; load_data = 32'd0;
    req_valid = 1'b0; req_addr = 32'd0; resp_ready = 1'b0;
    req_valid1 = 1'b0; req_addr1 = 32'd0; resp_ready1 = 1'b0;
    tick();
    tick();
    test_reset();
    test_basic();
    test_errors();
    test_backpressure();
    test_rw_collision();
    test_reset_mid();
    test_back_to_back_lat1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
